// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the RV32I writeback stage: widths, register index/word
// types, the reset redirect target and the commit-source encoding.
package writeback_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned IDXW = $clog2(NREG);

  typedef logic [IDXW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EXEC = 2'd1,
    WB_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/writeback_stage_regfile_2r1w.sv
// General register file: x0 hardwired to zero, one synchronous write port and two
// combinational write-first read ports.
module regfile_2r1w #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned IDXW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [IDXW-1:0] raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [IDXW-1:0] raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_live;
  logic            w_hit_a;
  logic            w_hit_b;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign w_wr_live = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_comb begin
    w_hit_a = w_wr_live && (waddr == raddr_a);
    w_hit_b = w_wr_live && (waddr == raddr_b);
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) begin
      rdata_a = w_hit_a ? wdata : r_regs[raddr_a];
    end
    if (raddr_b != '0) begin
      rdata_b = w_hit_b ? wdata : r_regs[raddr_b];
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: arbitrates exec results against load data, commits to
// the register file, forwards reads, registers redirects and counts retirements.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = writeback_stage_pkg::XLEN,
  parameter int unsigned     NREG     = writeback_stage_pkg::NREG,
  parameter logic [XLEN-1:0] RESET_PC = writeback_stage_pkg::RESET_PC,
  localparam int unsigned    IDXW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [IDXW-1:0] ex_rd,
  input  logic            ex_rd_we,
  input  logic [XLEN-1:0] ex_rd_value,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_next_pc,
  input  logic            dm_valid,
  output logic            dm_ready,
  input  logic [IDXW-1:0] dm_rd,
  input  logic [XLEN-1:0] dm_rdata,
  input  logic [IDXW-1:0] rs1_idx,
  input  logic [IDXW-1:0] rs2_idx,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [63:0]     instret
);

  wb_src_e         w_src;
  logic            w_rf_we;
  logic [IDXW-1:0] w_rf_waddr;
  logic [XLEN-1:0] w_rf_wdata;
  logic            w_retire;
  logic            w_take_redirect;

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic [63:0]     r_instret;

  assign dm_ready = 1'b1;
  assign ex_ready = !dm_valid;

  // Loads win the single write port; exec stalls behind them.
  always_comb begin
    w_src      = WB_NONE;
    w_rf_we    = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    if (dm_valid) begin
      w_src = WB_LOAD;
    end else if (ex_valid) begin
      w_src = WB_EXEC;
    end
    case (w_src)
      WB_LOAD: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = dm_rd;
        w_rf_wdata = dm_rdata;
      end
      WB_EXEC: begin
        w_rf_we    = ex_rd_we;
        w_rf_waddr = ex_rd;
        w_rf_wdata = ex_rd_value;
      end
      default: ;
    endcase
  end

  assign w_retire        = (w_src != WB_NONE);
  assign w_take_redirect = (w_src == WB_EXEC) && ex_redirect;

  // Gating with rst_n drops a transfer coinciding with reset, including its bypass.
  regfile_2r1w #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (w_rf_we && rst_n),
    .waddr   (w_rf_waddr),
    .wdata   (w_rf_wdata),
    .raddr_a (rs1_idx),
    .rdata_a (rs1_val),
    .raddr_b (rs2_idx),
    .rdata_b (rs2_val)
  );

  // Reset loads a pending redirect so fetch starts at RESET_PC on the first cycle out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b1;
      r_redirect_pc    <= RESET_PC;
    end else begin
      r_redirect_valid <= w_take_redirect;
      if (w_take_redirect) begin
        r_redirect_pc <= ex_next_pc & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign instret        = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: behavioural register-file/counter model compared every
// cycle, plus directed vectors with literal expectations.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [31:0] ex_rd_value;
  logic        ex_redirect;
  logic [31:0] ex_next_pc;
  logic        dm_valid;
  logic        dm_ready;
  logic [4:0]  dm_rd;
  logic [31:0] dm_rdata;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] instret;

  int n_checks = 0;
  int n_err    = 0;

  writeback_stage #(
    .XLEN(32),
    .NREG(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_rd          (ex_rd),
    .ex_rd_we       (ex_rd_we),
    .ex_rd_value    (ex_rd_value),
    .ex_redirect    (ex_redirect),
    .ex_next_pc     (ex_next_pc),
    .dm_valid       (dm_valid),
    .dm_ready       (dm_ready),
    .dm_rd          (dm_rd),
    .dm_rdata       (dm_rdata),
    .rs1_idx        (rs1_idx),
    .rs2_idx        (rs2_idx),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register file, retire count, pending redirect.
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic        m_rv;
  logic [31:0] m_rpc;
  bit          m_ok = 0;

  logic        c_commit;
  logic        c_is_exec;
  logic        c_we;
  logic [4:0]  c_rd;
  logic [31:0] c_val;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (rst_n && c_commit && c_we && c_rd == idx) return c_val;
    return m_regs[idx];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #2;
      // Decide what the upcoming edge commits, straight from the arbitration rules.
      c_commit  = dm_valid || ex_valid;
      c_is_exec = !dm_valid && ex_valid;
      c_we      = dm_valid ? 1'b1 : ex_rd_we;
      c_rd      = dm_valid ? dm_rd : ex_rd;
      c_val     = dm_valid ? dm_rdata : ex_rd_value;
      if (m_ok) begin
        chk("m_ex_ready", {63'd0, ex_ready}, {63'd0, !dm_valid});
        chk("m_dm_ready", {63'd0, dm_ready}, 64'd1);
        chk("m_redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
        chk("m_redirect_pc", {32'd0, redirect_pc}, {32'd0, m_rpc});
        chk("m_instret", instret, m_instret);
        if (rst_n) begin
          chk("m_rs1_val", {32'd0, rs1_val}, {32'd0, model_read(rs1_idx)});
          chk("m_rs2_val", {32'd0, rs2_val}, {32'd0, model_read(rs2_idx)});
        end
      end
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_instret = 64'd0;
        m_rv      = 1'b1;
        m_rpc     = 32'h0000_0000;
        m_ok      = 1;
      end else if (m_ok) begin
        if (c_commit) begin
          if (c_we && c_rd != 5'd0) m_regs[c_rd] = c_val;
          m_instret = m_instret + 64'd1;
        end
        m_rv = c_is_exec && ex_redirect;
        if (m_rv) m_rpc = {ex_next_pc[31:1], 1'b0};
      end
    end
  end

  task automatic idle_inputs();
    ex_valid    = 1'b0;
    ex_rd       = 5'd0;
    ex_rd_we    = 1'b0;
    ex_rd_value = 32'd0;
    ex_redirect = 1'b0;
    ex_next_pc  = 32'd0;
    dm_valid    = 1'b0;
    dm_rd       = 5'd0;
    dm_rdata    = 32'd0;
  endtask

  task automatic exec(input logic [4:0] rd, input logic we, input logic [31:0] val,
                      input logic redir, input logic [31:0] npc);
    ex_valid    = 1'b1;
    ex_rd       = rd;
    ex_rd_we    = we;
    ex_rd_value = val;
    ex_redirect = redir;
    ex_next_pc  = npc;
  endtask

  initial begin
    rst_n   = 1'b0;
    rs1_idx = 5'd0;
    rs2_idx = 5'd0;
    idle_inputs();

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("rst_redirect_pc", {32'd0, redirect_pc}, 64'h0);
    chk("rst_instret", instret, 64'd0);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1_idx = 5'(i);
      rs2_idx = 5'(31 - i);
      #3;
      if (i == 0) chk("rst_redirect_drop", {63'd0, redirect_valid}, 64'd0);
      chk("rst_rs1_zero", {32'd0, rs1_val}, 64'd0);
      chk("rst_rs2_zero", {32'd0, rs2_val}, 64'd0);
    end

    // Exec ADD to x5 with same-cycle bypass.
    @(negedge clk);
    exec(5'd5, 1'b1, 32'h0000_00AA, 1'b0, 32'd0);
    rs1_idx = 5'd5;
    #3;
    chk("add_bypass", {32'd0, rs1_val}, 64'hAA);
    chk("add_ex_ready", {63'd0, ex_ready}, 64'd1);
    @(negedge clk);
    idle_inputs();
    #3;
    chk("add_stored", {32'd0, rs1_val}, 64'hAA);
    chk("add_instret", instret, 64'd1);

    // Write to x0 is dropped but retires.
    @(negedge clk);
    exec(5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    rs1_idx = 5'd0;
    #3;
    chk("x0_same_cycle", {32'd0, rs1_val}, 64'd0);
    @(negedge clk);
    idle_inputs();
    #3;
    chk("x0_next_cycle", {32'd0, rs1_val}, 64'd0);
    chk("x0_instret", instret, 64'd2);

    // Load and exec both valid: load first, exec holds.
    @(negedge clk);
    dm_valid = 1'b1;
    dm_rd    = 5'd7;
    dm_rdata = 32'h1234_5678;
    exec(5'd8, 1'b1, 32'h0000_0009, 1'b0, 32'd0);
    rs1_idx = 5'd7;
    rs2_idx = 5'd8;
    #3;
    chk("both_ex_ready", {63'd0, ex_ready}, 64'd0);
    chk("both_load_bypass", {32'd0, rs1_val}, 64'h1234_5678);
    chk("both_exec_not_bypassed", {32'd0, rs2_val}, 64'd0);
    @(negedge clk);
    dm_valid = 1'b0;
    #3;
    chk("both_ex_ready2", {63'd0, ex_ready}, 64'd1);
    chk("both_x7_stored", {32'd0, rs1_val}, 64'h1234_5678);
    chk("both_exec_bypass", {32'd0, rs2_val}, 64'h9);
    chk("both_instret1", instret, 64'd3);
    @(negedge clk);
    idle_inputs();
    #3;
    chk("both_x8_stored", {32'd0, rs2_val}, 64'h9);
    chk("both_instret2", instret, 64'd4);

    // JALR with odd target.
    @(negedge clk);
    exec(5'd1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_1003);
    rs1_idx = 5'd1;
    @(negedge clk);
    idle_inputs();
    #3;
    chk("jalr_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("jalr_redirect_pc", {32'd0, redirect_pc}, 64'h1002);
    chk("jalr_x1", {32'd0, rs1_val}, 64'h104);
    chk("jalr_instret", instret, 64'd5);
    @(negedge clk);
    #3;
    chk("jalr_redirect_drop", {63'd0, redirect_valid}, 64'd0);
    chk("jalr_pc_hold", {32'd0, redirect_pc}, 64'h1002);

    // Untaken branch: no write, no redirect, still retires.
    @(negedge clk);
    exec(5'd9, 1'b0, 32'h0000_0077, 1'b0, 32'h0000_2000);
    rs1_idx = 5'd9;
    #3;
    chk("nowe_no_bypass", {32'd0, rs1_val}, 64'd0);
    @(negedge clk);
    idle_inputs();
    #3;
    chk("nowe_instret", instret, 64'd6);
    chk("nowe_no_redirect", {63'd0, redirect_valid}, 64'd0);

    // Fill every register through the load port.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      dm_valid = 1'b1;
      dm_rd    = 5'(i);
      dm_rdata = 32'(i) * 32'h0101_0101;
      rs1_idx  = 5'(i);
      rs2_idx  = 5'(i - 1);
    end
    @(negedge clk);
    idle_inputs();
    rs1_idx = 5'd31;
    rs2_idx = 5'd16;
    #3;
    chk("fill_x31", {32'd0, rs1_val}, 64'h1F1F_1F1F);
    chk("fill_x16", {32'd0, rs2_val}, 64'h1010_1010);
    chk("fill_instret", instret, 64'd37);

    // Reset lands on an exec transfer to x3.
    @(negedge clk);
    rst_n = 1'b0;
    exec(5'd3, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_4000);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    rs1_idx = 5'd3;
    rs2_idx = 5'd5;
    #3;
    chk("rst2_x3", {32'd0, rs1_val}, 64'd0);
    chk("rst2_x5", {32'd0, rs2_val}, 64'd0);
    chk("rst2_instret", instret, 64'd0);
    chk("rst2_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("rst2_redirect_pc", {32'd0, redirect_pc}, 64'h0);
    @(negedge clk);
    #3;
    chk("rst2_redirect_drop", {63'd0, redirect_valid}, 64'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final stage of the RV32I in-order pipeline. Accepts results from the exec stage and load data from the dmem path, and arbitrates between them. Commits results to the general register file (x0 hardwired to zero) and publishes write-first forwarded register reads to decode/exec. Also registers the branch/jump redirect for fetch and keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of general registers; index width is $clog2(NREG) = 5
RESET_PC, 32'h0000_0000, redirect target driven on the first cycle after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  exec result valid
ex_ready  out  1  writeback accepts exec result this cycle
ex_rd  in  5  exec destination register
ex_rd_we  in  1  exec result writes rd
ex_rd_value  in  XLEN  exec result value
ex_redirect  in  1  exec took jump or branch (JAL, JALR, taken B-type)
ex_next_pc  in  XLEN  exec redirect target
dm_valid  in  1  load data valid
dm_ready  out  1  writeback accepts load data, constant 1
dm_rd  in  5  load destination register
dm_rdata  in  XLEN  load data, already sign/zero-extended by dmem
rs1_idx, rs2_idx  in  5 each  forwarding read addresses
rs1_val, rs2_val  out  XLEN each  forwarded read data
redirect_valid  out  1  registered redirect pulse to fetch
redirect_pc  out  XLEN  registered redirect target
instret  out  64  retired-instruction count

Behaviour:
- Reset, while rst_n = 0 at a clock edge:
  - all registers are cleared to 0
  - instret = 0
  - redirect_pc = RESET_PC
  - redirect_valid = 1 for exactly the first cycle after rst_n rises, then 0
- Reset mid-operation: a transfer in the same cycle is discarded (no register write, no count).
- Arbitration:
  - dm_ready is constant 1.
  - ex_ready = !dm_valid, combinational.
  - Both valid in the same cycle: the load commits; exec must hold its inputs stable until ex_ready = 1.
- Commit:
  - Exec transfer = ex_valid & ex_ready.
  - Load transfer = dm_valid; the load always writes.
  - Register write happens at the clock edge of the transfer, only if the destination is nonzero (and ex_rd_we = 1 for exec).
  - A write to x0 is dropped silently; x0 always reads 0.
- Forwarding reads are combinational and write-first:
  - If rsN_idx equals the rd being committed this cycle (nonzero, write enabled), rsN_val = the incoming value.
  - Otherwise rsN_val = the stored register.
  - Index 0 always returns 0.
- Redirect:
  - On an exec transfer with ex_redirect = 1: next cycle redirect_valid = 1 and redirect_pc = ex_next_pc with bit 0 cleared (JALR masking).
  - Otherwise redirect_valid = 0.
  - redirect_pc holds its last value when redirect_valid = 0.
  - Latency: exactly 1 cycle.
- instret:
  - +1 per transfer (exec or load), including rd = x0 and non-writing branches.
  - At most +1 per cycle, since both valid implies only the load transfers.
  - Wraps modulo 2^64 with no flag.
- An exec result with ex_rd_we = 0 and ex_redirect = 0 (e.g. an untaken branch) still retires.
- Arithmetic is none beyond the 64-bit increment; all data paths are XLEN wide with no extension.

Decomposition:
- Shared defs package: XLEN, NREG, reg_idx_t (5-bit), word_t, RESET_PC.
- One sub-module, regfile_2r1w: 32x32 storage, x0 hardwired, synchronous write, two combinational write-first read ports.
- Arbitration, redirect and instret stay in writeback_stage.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, then release.
  - First cycle: redirect_valid = 1, redirect_pc = 0x0; then redirect_valid = 0.
  - instret = 0; rs1_val = rs2_val = 0 for every index.
- Exec ADD to x5 = 0x0000_00AA with rs1_idx = 5 in the same cycle:
  - rs1_val = 0xAA combinationally (bypass); after the edge, stored x5 = 0xAA.
  - instret = 1.
- Exec write to x0 = 0xFFFF_FFFF:
  - rs1_idx = 0 reads 0 in the same cycle and the next; instret increments.
- Load x7 = 0x1234_5678 and exec x8 = 0x9 both valid:
  - Cycle 1: x7 commits, ex_ready = 0.
  - Cycle 2: x8 commits.
  - instret +2 total over the two cycles.
- JALR redirect: ex_next_pc = 0x0000_1003, ex_redirect = 1, rd = x1 = 0x104.
  - Next cycle: redirect_valid = 1, redirect_pc = 0x0000_1002, x1 = 0x104.
  - Following cycle: redirect_valid = 0.
- Reset asserted during an exec transfer to x3 = 0x55:
  - x3 remains 0, instret = 0, redirect_valid = 1 for exactly the first cycle after release.
